// File: rtl/traffic_light_monitor.sv
// ============================================================================
// traffic_light_monitor : passive checker for the four-way light buses
// Rev 1.0
// ============================================================================
`default_nettype none

module traffic_light_monitor #(
  parameter int DWELL = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] n_lights,
  input  logic [1:0] s_lights,
  input  logic [1:0] e_lights,
  input  logic [1:0] w_lights,
  input  logic       clr_fault,
  output logic [2:0] phase,
  output logic       locked,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] rotations
);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [2:0] FC_ILLEGAL  = 3'd1;
  localparam logic [2:0] FC_CONFLICT = 3'd2;
  localparam logic [2:0] FC_ALL_RED  = 3'd3;
  localparam logic [2:0] FC_SEQUENCE = 3'd4;
  localparam logic [2:0] FC_EARLY    = 3'd5;
  localparam logic [2:0] FC_OVERSTAY = 3'd6;
  localparam logic [7:0] DWELL_LAST  = 8'(DWELL - 1);

  state_t     state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic [7:0] dwell_q, dwell_d;
  logic [2:0] prev_p_q, prev_p_d;
  logic       prev_valid_q, prev_valid_d;
  logic [2:0] fault_code_q, fault_code_d;
  logic [7:0] rot_q, rot_d;

  logic [3:0] bus_nz;
  logic       is_illegal;
  logic       is_conflict;
  logic       is_all_red;
  logic [1:0] dir;
  logic [1:0] dir_code;
  logic [2:0] p;

  // Bus order within bus_nz doubles as the direction index of the phase.
  always_comb begin
    bus_nz      = {w_lights != 2'b00, e_lights != 2'b00,
                   s_lights != 2'b00, n_lights != 2'b00};
    is_illegal  = (n_lights == 2'b11) || (s_lights == 2'b11) ||
                  (e_lights == 2'b11) || (w_lights == 2'b11);
    is_conflict = !is_illegal && ($countones(bus_nz) > 1);
    is_all_red  = (bus_nz == 4'b0000);
    dir         = 2'd0;
    dir_code    = n_lights;
    if (bus_nz[1]) begin
      dir      = 2'd1;
      dir_code = s_lights;
    end else if (bus_nz[2]) begin
      dir      = 2'd2;
      dir_code = e_lights;
    end else if (bus_nz[3]) begin
      dir      = 2'd3;
      dir_code = w_lights;
    end
    p = {dir, dir_code == 2'b01};
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    dwell_d      = dwell_q;
    prev_p_d     = prev_p_q;
    prev_valid_d = prev_valid_q;
    fault_code_d = fault_code_q;
    rot_d        = rot_q;

    unique case (state_q)
      ST_SYNC: begin
        if (is_illegal) begin
          state_d      = ST_FAULT;
          fault_code_d = FC_ILLEGAL;
        end else if (is_conflict) begin
          state_d      = ST_FAULT;
          fault_code_d = FC_CONFLICT;
        end else if (is_all_red) begin
          prev_valid_d = 1'b0;
        end else if (prev_valid_q && (p == prev_p_q + 3'd1)) begin
          state_d = ST_TRACK;
          phase_d = p;
          dwell_d = 8'd0;
        end else begin
          prev_p_d     = p;
          prev_valid_d = 1'b1;
        end
      end
      ST_TRACK: begin
        if (is_illegal || is_conflict || is_all_red) begin
          state_d      = ST_FAULT;
          fault_code_d = is_illegal  ? FC_ILLEGAL :
                         is_conflict ? FC_CONFLICT : FC_ALL_RED;
        end else if (p == phase_q) begin
          if (dwell_q == DWELL_LAST) begin
            state_d      = ST_FAULT;
            fault_code_d = FC_OVERSTAY;
          end else if (dwell_q != 8'hFF) begin
            dwell_d = dwell_q + 8'd1;
          end
        end else if (p == phase_q + 3'd1) begin
          if (dwell_q != DWELL_LAST) begin
            state_d      = ST_FAULT;
            fault_code_d = FC_EARLY;
          end else begin
            phase_d = p;
            dwell_d = 8'd0;
            if (p == 3'd0) rot_d = rot_q + 8'd1;
          end
        end else begin
          state_d      = ST_FAULT;
          fault_code_d = FC_SEQUENCE;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase

    // A clear overrides anything detected on the same sample.
    if (clr_fault) begin
      state_d      = ST_SYNC;
      fault_code_d = 3'd0;
      prev_valid_d = 1'b0;
      phase_d      = phase_q;
      dwell_d      = dwell_q;
      prev_p_d     = prev_p_q;
      rot_d        = rot_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_SYNC;
      phase_q      <= 3'd0;
      dwell_q      <= 8'd0;
      prev_p_q     <= 3'd0;
      prev_valid_q <= 1'b0;
      fault_code_q <= 3'd0;
      rot_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      dwell_q      <= dwell_d;
      prev_p_q     <= prev_p_d;
      prev_valid_q <= prev_valid_d;
      fault_code_q <= fault_code_d;
      rot_q        <= rot_d;
    end
  end

  assign phase      = phase_q;
  assign locked     = (state_q == ST_TRACK);
  assign fault      = (state_q == ST_FAULT);
  assign fault_code = fault_code_q;
  assign rotations  = rot_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
// ============================================================================
// tb_traffic_light_monitor : vector table, directed corners and random traffic
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_traffic_light_monitor;

  localparam int DWELL = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] n_l, s_l, e_l, w_l;
  logic       clr;
  logic [2:0] phase;
  logic       locked;
  logic       fault;
  logic [2:0] fault_code;
  logic [7:0] rotations;

  traffic_light_monitor #(.DWELL(DWELL)) dut (
    .clk(clk), .rst(rst),
    .n_lights(n_l), .s_lights(s_l), .e_lights(e_l), .w_lights(w_l),
    .clr_fault(clr),
    .phase(phase), .locked(locked), .fault(fault),
    .fault_code(fault_code), .rotations(rotations)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: mode 0 sync, 1 track, 2 fault; held = samples seen in phase.
  int m_mode, m_phase, m_held, m_prev, m_code, m_rot;

  function automatic void model_reset();
    m_mode = 0; m_phase = 0; m_held = 0; m_prev = -1; m_code = 0; m_rot = 0;
  endfunction

  function automatic void model_step(input logic [1:0] n, s, e, w, input logic c);
    int lt[4];
    int nzc, dir, cls, p;
    bit ill;
    lt  = '{int'(n), int'(s), int'(e), int'(w)};
    nzc = 0; dir = 0; ill = 0;
    for (int i = 3; i >= 0; i--) begin
      if (lt[i] == 3) ill = 1;
      if (lt[i] != 0) begin nzc++; dir = i; end
    end
    cls = ill ? 1 : (nzc > 1) ? 2 : (nzc == 0) ? 3 : 0;
    p   = dir * 2 + ((lt[dir] == 1) ? 1 : 0);
    if (c) begin
      m_mode = 0; m_code = 0; m_prev = -1;
      return;
    end
    case (m_mode)
      0: begin
        if (cls == 1 || cls == 2) begin m_mode = 2; m_code = cls; end
        else if (cls == 3) m_prev = -1;
        else if (m_prev >= 0 && p == (m_prev + 1) % 8) begin
          m_mode = 1; m_phase = p; m_held = 1;
        end else m_prev = p;
      end
      1: begin
        if (cls != 0) begin m_mode = 2; m_code = cls; end
        else if (p == m_phase) begin
          if (m_held == DWELL) begin m_mode = 2; m_code = 6; end
          else m_held++;
        end else if (p == (m_phase + 1) % 8) begin
          if (m_held < DWELL) begin m_mode = 2; m_code = 5; end
          else begin
            m_phase = p; m_held = 1;
            if (p == 0) m_rot = (m_rot + 1) % 256;
          end
        end else begin m_mode = 2; m_code = 4; end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [15:0] dut_vec();
    return {phase, locked, fault, fault_code, rotations};
  endfunction

  function automatic logic [15:0] model_vec();
    return {3'(m_phase), m_mode == 1, m_mode == 2, 3'(m_code), 8'(m_rot)};
  endfunction

  task automatic step(input logic [1:0] n, s, e, w, input logic c);
    n_l = n; s_l = s; e_l = e; w_l = w; clr = c;
    @(posedge clk);
    model_step(n, s, e, w, c);
    #1;
    chk("model", dut_vec(), model_vec());
  endtask

  task automatic ph(input int p, input logic c = 1'b0);
    logic [1:0] b[4];
    b = '{default: 2'b00};
    b[p / 2] = (p % 2 != 0) ? 2'b01 : 2'b10;
    step(b[0], b[1], b[2], b[3], c);
  endtask

  typedef struct {
    logic [1:0] n, s, e, w;
    logic       c;
    logic [2:0] ph;
    logic       lk, ft;
    logic [2:0] fc;
  } vec_t;

  vec_t tbl[17];

  initial begin
    tbl[0]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0};
    tbl[1]  = '{2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0};
    tbl[2]  = '{2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0};
    tbl[3]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0};
    tbl[4]  = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0};
    tbl[5]  = '{2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 3'd2, 1'b1, 1'b0, 3'd0};
    tbl[6]  = '{2'b00, 2'b10, 2'b10, 2'b00, 1'b0, 3'd2, 1'b0, 1'b1, 3'd2};
    tbl[7]  = '{2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 3'd2, 1'b0, 1'b1, 3'd2};
    tbl[8]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'd2, 1'b0, 1'b0, 3'd0};
    tbl[9]  = '{2'b00, 2'b00, 2'b00, 2'b10, 1'b0, 3'd2, 1'b0, 1'b0, 3'd0};
    tbl[10] = '{2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 3'd7, 1'b1, 1'b0, 3'd0};
    tbl[11] = '{2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 3'd7, 1'b0, 1'b1, 3'd1};
    tbl[12] = '{2'b10, 2'b10, 2'b00, 2'b00, 1'b1, 3'd7, 1'b0, 1'b0, 3'd0};
    tbl[13] = '{2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 3'd7, 1'b0, 1'b1, 3'd2};
    tbl[14] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'd7, 1'b0, 1'b0, 3'd0};
    tbl[15] = '{2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 3'd7, 1'b0, 1'b0, 3'd0};
    tbl[16] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'd7, 1'b0, 1'b0, 3'd0};

    n_l = 2'b00; s_l = 2'b00; e_l = 2'b00; w_l = 2'b00; clr = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("reset_state", dut_vec(), 16'h0000);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].n, tbl[i].s, tbl[i].e, tbl[i].w, tbl[i].c);
      chk($sformatf("table_%0d", i), {10'd0, phase, locked, fault, fault_code},
          {10'd0, tbl[i].ph, tbl[i].lk, tbl[i].ft, tbl[i].fc});
    end

    // Three legal rotations starting from N.
    ph(0, 1'b1);
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < 8; p++)
        for (int k = 0; k < DWELL; k++) begin
          ph(p);
          if (r == 0 && p == 1 && k == 0)
            chk("lock_on_first_ny", {12'd0, locked, phase}, {12'd0, 1'b1, 3'd1});
        end
    chk("rot_after_3_loops", {7'd0, fault, rotations}, {7'd0, 1'b0, 8'd2});
    ph(0);
    chk("rot_third_accept", {7'd0, fault, rotations}, {7'd0, 1'b0, 8'd3});

    // Early change: E held only 5 cycles.
    for (int k = 1; k < DWELL; k++) ph(0);
    for (int p = 1; p < 4; p++) for (int k = 0; k < DWELL; k++) ph(p);
    for (int k = 0; k < 5; k++) ph(4);
    ph(5);
    chk("early", {12'd0, fault, fault_code}, {12'd0, 1'b1, 3'd5});

    // Overstay: W held 9 cycles.
    ph(5, 1'b1);
    ph(5);
    for (int k = 0; k < DWELL; k++) ph(6);
    chk("w_8_ok", {12'd0, fault, fault_code}, 16'h0000);
    ph(6);
    chk("overstay", {12'd0, fault, fault_code}, {12'd0, 1'b1, 3'd6});

    // Sequence jump N_Y -> E, then clear on an ALL_RED sample and relock.
    ph(6, 1'b1);
    ph(0);
    ph(1);
    ph(4);
    chk("sequence", {12'd0, fault, fault_code}, {12'd0, 1'b1, 3'd4});
    step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    chk("clear", {11'd0, locked, fault, fault_code}, 16'h0000);
    ph(2);
    chk("relock_wait", {15'd0, locked}, 16'h0000);
    ph(3);
    chk("relock", {12'd0, locked, phase}, {12'd0, 1'b1, 3'd3});

    // Asynchronous reset between edges.
    ph(3); ph(3);
    #2 rst = 1'b0;
    #1;
    chk("async_reset", dut_vec(), 16'h0000);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ph(3);
      chk("post_reset_unlocked", {15'd0, locked}, 16'h0000);
    end
    ph(4);
    chk("post_reset_relock", {12'd0, locked, phase}, {12'd0, 1'b1, 3'd4});

    // Randomized traffic: mostly legal rotation, with glitches, odd dwells and clears.
    begin
      int gp, gh, glen, r;
      gp = 4; gh = 1; glen = DWELL;
      for (int i = 0; i < 3000; i++) begin
        r = $urandom_range(0, 999);
        if ((m_mode == 2 && r < 50) || r < 3) ph(gp, 1'b1);
        else if (r < 6) step(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'b0);
        else begin
          ph(gp);
          gh++;
          if (gh >= glen) begin
            gp = (gp + 1) % 8;
            gh = 0;
            glen = ($urandom_range(0, 29) == 0) ? $urandom_range(DWELL - 2, DWELL + 1) : DWELL;
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
